// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - register map and timing defaults shared by board_io
package board_io_pkg;

  typedef enum logic [1:0] {
    ADDR_LED       = 2'd0,
    ADDR_BTN_STATE = 2'd1,
    ADDR_BTN_EVENT = 2'd2,
    ADDR_IRQ_MASK  = 2'd3
  } reg_addr_e;

  // 10 ms of clk_25mhz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: two-flop synchroniser, debounce counter, stable level
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk_25mhz,
  input  logic reset_n,
  input  logic btn,
  output logic stable,
  output logic rise_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // rise_pulse is combinational so the event lands on the same edge stable does
  assign accept     = (sync2 != stable) && (cnt == CNT_LAST);
  assign rise_pulse = accept && sync2;

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/board_io.sv
// rtl/board_io.sv - memory-mapped LED/button peripheral with debounced, latched, maskable press events
module board_io
  import board_io_pkg::*;
#(
  parameter int NUM_LED         = 8,
  parameter int NUM_BTN         = 7,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk_25mhz,
  input  logic               reset_n,
  input  logic [1:0]         addr,
  input  logic               write_enable,
  input  logic               read_enable,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               read_valid,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_LED-1:0] led,
  output logic               irq
);

  logic [NUM_LED-1:0] led_q;
  logic [NUM_BTN-1:0] btn_stable;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] event_q;
  logic [NUM_BTN-1:0] mask_q;
  logic [NUM_BTN-1:0] event_clr;
  logic               wr_led;
  logic               wr_event;
  logic               wr_mask;
  logic [31:0]        rd_mux;
  logic               unused_write_bits;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk_25mhz (clk_25mhz),
      .reset_n   (reset_n),
      .btn       (btn[i]),
      .stable    (btn_stable[i]),
      .rise_pulse(btn_rise[i])
    );
  end

  assign wr_led            = write_enable && (addr == ADDR_LED);
  assign wr_event          = write_enable && (addr == ADDR_BTN_EVENT);
  assign wr_mask           = write_enable && (addr == ADDR_IRQ_MASK);
  assign event_clr         = wr_event ? write_data[NUM_BTN-1:0] : '0;
  assign led               = led_q;
  assign unused_write_bits = ^write_data;

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_LED:       rd_mux[NUM_LED-1:0] = led_q;
      ADDR_BTN_STATE: rd_mux[NUM_BTN-1:0] = btn_stable;
      ADDR_BTN_EVENT: rd_mux[NUM_BTN-1:0] = event_q;
      ADDR_IRQ_MASK:  rd_mux[NUM_BTN-1:0] = mask_q;
    endcase
  end

  // Reads sample pre-edge register values, so a same-cycle write is not visible yet
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= '0;
      event_q    <= '0;
      mask_q     <= '0;
      irq        <= 1'b0;
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      if (wr_led) led_q <= write_data[NUM_LED-1:0];
      if (wr_mask) mask_q <= write_data[NUM_BTN-1:0];
      event_q    <= (event_q & ~event_clr) | btn_rise;
      irq        <= |(event_q & mask_q);
      read_valid <= read_enable;
      if (read_enable) read_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_board_io.sv
// tb/tb_board_io.sv - scoreboard bench for board_io with a sliding-window debounce model
module tb_board_io;

  localparam int NUM_LED = 8;
  localparam int NUM_BTN = 7;
  localparam int DEB     = 8;

  logic               clk_25mhz = 1'b0;
  logic               reset_n;
  logic [1:0]         addr;
  logic               write_enable;
  logic               read_enable;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               read_valid;
  logic [NUM_BTN-1:0] btn;
  logic [NUM_LED-1:0] led;
  logic               irq;

  int errors = 0;
  int checks = 0;

  board_io #(
    .NUM_LED        (NUM_LED),
    .NUM_BTN        (NUM_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk_25mhz   (clk_25mhz),
    .reset_n     (reset_n),
    .addr        (addr),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .write_data  (write_data),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .btn         (btn),
    .led         (led),
    .irq         (irq)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  // Reference model state
  logic [NUM_LED-1:0] m_led;
  logic [NUM_BTN-1:0] m_state;
  logic [NUM_BTN-1:0] m_event;
  logic [NUM_BTN-1:0] m_mask;
  logic               m_irq;
  logic [NUM_BTN-1:0] hist[$];
  logic [31:0]        exp_q[$];
  logic [31:0]        m_last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led     = '0;
    m_state   = '0;
    m_event   = '0;
    m_mask    = '0;
    m_irq     = 1'b0;
    m_last_rd = '0;
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
  endtask

  // A level is accepted once the pin, seen two samples late, held it for DEB samples
  task automatic model_step();
    logic [NUM_BTN-1:0] all1;
    logic [NUM_BTN-1:0] any1;
    logic [NUM_BTN-1:0] nstate;
    logic [NUM_BTN-1:0] rise;
    logic               nirq;
    logic [31:0]        rv;
    hist.push_back(btn);
    void'(hist.pop_front());
    all1 = '1;
    any1 = '0;
    for (int k = 0; k < DEB; k++) begin
      all1 &= hist[k];
      any1 |= hist[k];
    end
    nstate = (m_state | all1) & any1;
    rise   = nstate & ~m_state;
    nirq   = |(m_event & m_mask);
    if (read_enable) begin
      case (addr)
        2'd0:    rv = 32'(m_led);
        2'd1:    rv = 32'(m_state);
        2'd2:    rv = 32'(m_event);
        default: rv = 32'(m_mask);
      endcase
      exp_q.push_back(rv);
    end
    if (write_enable) begin
      case (addr)
        2'd0:    m_led = write_data[NUM_LED-1:0];
        2'd2:    m_event = m_event & ~write_data[NUM_BTN-1:0];
        2'd3:    m_mask = write_data[NUM_BTN-1:0];
        default: ;
      endcase
    end
    m_event = m_event | rise;
    m_state = nstate;
    m_irq   = nirq;
  endtask

  always @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Monitor: compares outputs against the model away from the active edge
  always @(negedge clk_25mhz) begin
    logic [31:0] rv;
    if (reset_n) begin
      check("led", 32'(led), 32'(m_led));
      check("irq", 32'(irq), 32'(m_irq));
      if (read_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_unexpected: got read_valid=1 expected no pending read at %0t", $time);
        end else begin
          rv = exp_q.pop_front();
          check("read_data", read_data, rv);
          m_last_rd = rv;
        end
      end else begin
        check("read_hold", read_data, m_last_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr         = a;
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    addr        = a;
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    addr         = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = '0;
    btn          = '0;
    reset_n      = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_read_valid", 32'(read_valid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick();

    // LED write and readback
    bus_write(2'd0, 32'hFFFF_FFA5);
    check("led_a5", 32'(led), 32'hA5);
    bus_read(2'd0);
    check("led_rd_valid", 32'(read_valid), 32'h1);
    check("led_rd_data", read_data, 32'h0000_00A5);

    // Short glitch on btn[0]
    btn[0] = 1'b1;
    repeat (5) tick();
    btn[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("glitch_irq", 32'(irq), 32'h0);
    end
    bus_read(2'd1);
    check("glitch_state", read_data, 32'h0);
    bus_read(2'd2);
    check("glitch_event", read_data, 32'h0);

    // Clean press of btn[2] with mask bit 2
    bus_write(2'd3, 32'h04);
    btn[2] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 10 || i == 11) begin
        addr        = 2'd1;
        read_enable = 1'b1;
      end
      tick();
      read_enable = 1'b0;
      if (i == 10) begin
        check("press_state_t10", read_data, 32'h0);
        check("press_irq_t10", 32'(irq), 32'h0);
      end
      if (i == 11) begin
        check("press_state_t11", read_data, 32'h04);
        check("press_irq_t11", 32'(irq), 32'h1);
      end
    end
    bus_read(2'd2);
    check("press_event", read_data, 32'h04);

    // Bouncing btn[1]
    btn[1] = 1'b1;
    repeat (3) tick();
    btn[1] = 1'b0;
    tick();
    btn[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 10 || i == 11) begin
        addr        = 2'd1;
        read_enable = 1'b1;
      end
      tick();
      read_enable = 1'b0;
      if (i == 10) check("bounce_state_t10", read_data, 32'h04);
      if (i == 11) check("bounce_state_t11", read_data, 32'h06);
    end
    bus_read(2'd2);
    check("bounce_event", read_data, 32'h06);

    // W1C colliding with a new press of btn[2]
    btn[2] = 1'b0;
    repeat (12) tick();
    btn[2] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 10) begin
        addr         = 2'd2;
        write_data   = 32'h04;
        write_enable = 1'b1;
      end
      tick();
      write_enable = 1'b0;
    end
    check("collide_irq", 32'(irq), 32'h1);
    bus_read(2'd2);
    check("collide_event", read_data, 32'h06);
    bus_write(2'd2, 32'h04);
    check("clear_irq_same", 32'(irq), 32'h1);
    tick();
    check("clear_irq_next", 32'(irq), 32'h0);
    bus_read(2'd2);
    check("clear_event", read_data, 32'h02);

    // Masking removes irq but keeps the event
    bus_write(2'd3, 32'h02);
    tick();
    check("mask_irq_on", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h00);
    tick();
    check("mask_irq_off", 32'(irq), 32'h0);
    bus_read(2'd2);
    check("mask_event_kept", read_data, 32'h02);

    // Reset in the middle of a debounce on btn[3]
    btn = 7'h08;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_read_data", read_data, 32'h0);
    check("midrst_read_valid", 32'(read_valid), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    bus_write(2'd3, 32'h08);
    for (int i = 2; i <= 12; i++) begin
      tick();
      if (i == 10) check("rst_hold_irq_t10", 32'(irq), 32'h0);
      if (i == 11) check("rst_hold_irq_t11", 32'(irq), 32'h1);
    end
    bus_read(2'd1);
    check("rst_hold_state", read_data, 32'h08);
    bus_read(2'd2);
    check("rst_hold_event", read_data, 32'h08);

    // Random traffic, fast then slow pin activity
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_BTN; c++) begin
        if ($urandom_range(0, (n < 1500) ? 11 : 29) == 0) btn[c] = ~btn[c];
      end
      read_enable  = ($urandom_range(0, 2) == 0);
      write_enable = ($urandom_range(0, 3) == 0);
      addr         = 2'($urandom_range(0, 3));
      write_data   = $urandom;
      tick();
    end
    read_enable  = 1'b0;
    write_enable = 1'b0;
    repeat (4) tick();
    check("pending_reads", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
